// File: rtl/bp_resolve_queue.sv
// Branch-resolution queue: holds in-order predictions from IF, matches the
// oldest one against the EX outcome, and produces the registered redirect,
// the predictor-update strobe and saturating branch statistics.
module bp_resolve_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid_i,
  input  logic [31:0]                enq_pc_i,
  input  logic                       enq_pred_taken_i,
  input  logic [31:0]                enq_pred_target_i,
  output logic                       enq_ready_o,
  input  logic                       ex_valid_i,
  input  logic [31:0]                ex_pc_i,
  input  logic                       ex_taken_i,
  input  logic [31:0]                ex_target_i,
  input  logic                       flush_i,
  output logic                       mispredict_o,
  output logic [31:0]                redirect_pc_o,
  output logic                       upd_valid_o,
  output logic [31:0]                upd_pc_o,
  output logic                       upd_taken_o,
  output logic                       orphan_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [31:0]                branch_count_o,
  output logic [31:0]                mispredict_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage; contents are only meaningful between head and tail.
  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          mispredict_q, mispredict_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          upd_valid_q, upd_valid_d;
  logic [31:0]   upd_pc_q, upd_pc_d;
  logic          upd_taken_q, upd_taken_d;
  logic          orphan_q, orphan_d;
  logic [31:0]   branch_count_q, branch_count_d;
  logic [31:0]   mispredict_count_q, mispredict_count_d;

  logic          head_match;
  logic          hit;
  logic          orphan_evt;
  logic          eff_pred_taken;
  logic [31:0]   eff_pred_target;
  logic          mispredict_evt;
  logic          do_enq;
  logic          clear_q;

  // Resolution decode: an orphan is treated as a not-taken prediction.
  always_comb begin
    head_match      = (count_q != '0) && (pc_mem[head_q] == ex_pc_i);
    hit             = ex_valid_i && head_match;
    orphan_evt      = ex_valid_i && !head_match;
    eff_pred_taken  = hit ? taken_mem[head_q] : 1'b0;
    eff_pred_target = target_mem[head_q];
    mispredict_evt  = ex_valid_i &&
                      ((eff_pred_taken != ex_taken_i) ||
                       (eff_pred_taken && ex_taken_i && (eff_pred_target != ex_target_i)));
    enq_ready_o     = (count_q != FULL_COUNT);
    // Anything fetched alongside a redirect or flush is on the wrong path.
    do_enq          = enq_valid_i && enq_ready_o && !flush_i && !mispredict_evt;
    clear_q         = flush_i || mispredict_evt;
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_q) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (hit) begin
        head_d = head_q + AW'(1);
      end
      if (do_enq) begin
        tail_d = tail_q + AW'(1);
      end
      case ({do_enq, hit})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next values for the registered resolution outputs and statistics.
  always_comb begin
    mispredict_d       = mispredict_evt;
    upd_valid_d        = ex_valid_i;
    orphan_d           = orphan_evt;
    redirect_pc_d      = redirect_pc_q;
    upd_pc_d           = upd_pc_q;
    upd_taken_d        = upd_taken_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_valid_i) begin
      redirect_pc_d = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
      upd_pc_d      = ex_pc_i;
      upd_taken_d   = ex_taken_i;
      if (branch_count_q != 32'hFFFF_FFFF) begin
        branch_count_d = branch_count_q + 32'd1;
      end
    end
    if (mispredict_evt && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  // Entry write; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && do_enq) begin
      pc_mem[tail_q]     <= enq_pc_i;
      taken_mem[tail_q]  <= enq_pred_taken_i;
      target_mem[tail_q] <= enq_pred_target_i;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      upd_valid_q        <= 1'b0;
      upd_pc_q           <= '0;
      upd_taken_q        <= 1'b0;
      orphan_q           <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      upd_valid_q        <= upd_valid_d;
      upd_pc_q           <= upd_pc_d;
      upd_taken_q        <= upd_taken_d;
      orphan_q           <= orphan_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict_o       = mispredict_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign upd_valid_o        = upd_valid_q;
  assign upd_pc_o           = upd_pc_q;
  assign upd_taken_o        = upd_taken_q;
  assign orphan_o           = orphan_q;
  assign occupancy_o        = count_q;
  assign branch_count_o     = branch_count_q;
  assign mispredict_count_o = mispredict_count_q;

endmodule
